// File: rtl/power_alu_ctrl_pkg.sv
// Shared encodings for the power ALU controller: opcodes, FSM states and
// result-mux selects.
package power_alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_POW = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_EXEC     = 2'b01,
    S_POW_LOOP = 2'b10,
    S_DONE     = 2'b11
  } state_e;

  localparam logic [1:0] SEL_SUM  = 2'b00;
  localparam logic [1:0] SEL_DIFF = 2'b01;
  localparam logic [1:0] SEL_PROD = 2'b10;

  function automatic logic [1:0] op_to_sel(input op_e op);
    case (op)
      OP_ADD:  return SEL_SUM;
      OP_SUB:  return SEL_DIFF;
      default: return SEL_PROD;
    endcase
  endfunction

endpackage

// File: rtl/power_alu_ctrl_if.sv
// Command/result bundle between the command source (master) and the
// power ALU controller (slave).
interface power_alu_ctrl_if #(parameter int WIDTH = 8);
  logic                    start;
  logic [1:0]              op;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] result;
  logic [1:0]              mux_ctrl;

  modport master (output start, op, a, b, input busy, done, result, mux_ctrl);
  modport slave  (input start, op, a, b, output busy, done, result, mux_ctrl);
endinterface

// File: rtl/power_alu_ctrl_alumux.sv
// 3-way result selector: sum, difference or product.
module alumux
  import power_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  output logic [WIDTH-1:0] s,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c
);

  always_comb begin
    s = '0;
    case (ctrl)
      SEL_SUM:  s = a;
      SEL_DIFF: s = b;
      SEL_PROD: s = c;
      default:  s = '0;
    endcase
  end

endmodule

// File: rtl/power_alu_ctrl.sv
// Multi-cycle controller for the 8-bit signed ALU: single-cycle ADD/SUB/MUL
// and iterated-multiply POW, with start/busy/done handshake.
//
// state      | meaning
// S_IDLE     | waiting for start, operands latched on acceptance
// S_EXEC     | ADD/SUB/MUL result captured from the mux
// S_POW_LOOP | one settle cycle, then acc <= acc*a once per exponent count
// S_DONE     | one-cycle done pulse, back to idle
module power_alu_ctrl
  import power_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  power_alu_ctrl_if.slave   bus
);

  localparam logic signed [WIDTH-1:0] ONE = 1;

  state_e                  state;
  logic signed [WIDTH-1:0] a_q, b_q, acc;
  logic [CNT_W-1:0]        cnt;
  logic                    pow_settle;
  logic signed [WIDTH-1:0] sum, diff, prod, mul_y, mux_s;

  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;
  assign mul_y = (state == S_POW_LOOP) ? acc : b_q;
  // Low WIDTH bits of the signed product are the same as those of the full 2*WIDTH product.
  assign prod  = a_q * mul_y;

  alumux #(.WIDTH(WIDTH)) u_alumux (
    .s    (mux_s),
    .ctrl (bus.mux_ctrl),
    .a    (sum),
    .b    (diff),
    .c    (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      cnt          <= '0;
      pow_settle   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.mux_ctrl <= SEL_SUM;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            if (op_e'(bus.op) == OP_POW) begin
              acc <= ONE;
              if (bus.b == '0) begin
                bus.result <= ONE;
                bus.done   <= 1'b1;
                state      <= S_DONE;
              end else begin
                cnt          <= CNT_W'(bus.b);
                pow_settle   <= 1'b1;
                bus.busy     <= 1'b1;
                bus.mux_ctrl <= SEL_PROD;
                state        <= S_POW_LOOP;
              end
            end else begin
              bus.busy     <= 1'b1;
              bus.mux_ctrl <= op_to_sel(op_e'(bus.op));
              state        <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          bus.result   <= mux_s;
          bus.mux_ctrl <= SEL_SUM;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          state        <= S_DONE;
        end
        S_POW_LOOP: begin
          // First loop cycle lets the product select settle before accumulating.
          if (pow_settle) begin
            pow_settle <= 1'b0;
          end else begin
            acc <= mux_s;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              bus.result   <= mux_s;
              bus.mux_ctrl <= SEL_SUM;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_alu_ctrl.sv
// Directed bench for power_alu_ctrl: arithmetic, POW latency, handshake and
// asynchronous reset behaviour against hand-computed values.
module tb_power_alu_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  power_alu_ctrl_if #(.WIDTH(8)) bus ();

  power_alu_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issues one op, scrambles the inputs after acceptance, and measures
  // latency (edges, accepting edge = 1), busy cycles and the busy-time select.
  task automatic run_op(input logic [1:0] o, input int x, input int y,
                        output int lat, output int bcyc, output int msel);
    bus.op = o; bus.a = 8'(x); bus.b = 8'(y); bus.start = 1'b1;
    @(posedge clk);
    lat = 1; bcyc = 0; msel = -1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    while (!bus.done && lat < 300) begin
      if (bus.busy) begin
        bcyc++;
        msel = int'(bus.mux_ctrl);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    string tag;
    logic [1:0] op;
    int a, b, res, lat, bcyc, msel;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, bcyc, msel, ndone, nbusy;
    checks = 0; failures = 0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_mux", int'(bus.mux_ctrl), 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{"add",     2'b00,  5,  10,   15,   2,   1,  0});
    vecs.push_back('{"sub",     2'b01,  5,  10,   -5,   2,   1,  1});
    vecs.push_back('{"mul",     2'b10, 20,  10,  -56,   2,   1,  2});
    vecs.push_back('{"pow3_4",  2'b11,  3,   4,   81,   6,   5,  2});
    vecs.push_back('{"pown2_3", 2'b11, -2,   3,   -8,   5,   4,  2});
    vecs.push_back('{"pow2_8",  2'b11,  2,   8,    0,  10,   9,  2});
    vecs.push_back('{"pow2_7",  2'b11,  2,   7, -128,   9,   8,  2});
    vecs.push_back('{"pow7_0",  2'b11,  7,   0,    1,   1,   0, -1});
    vecs.push_back('{"pown1_255", 2'b11, -1, 255, -1, 257, 256,  2});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc, msel);
      chk({vecs[i].tag, "_result"}, int'(bus.result), vecs[i].res);
      chk({vecs[i].tag, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].tag, "_busy_cycles"}, bcyc, vecs[i].bcyc);
      chk({vecs[i].tag, "_mux"}, msel, vecs[i].msel);
      @(negedge clk);
      chk({vecs[i].tag, "_done_pulse"}, int'(bus.done), 0);
      chk({vecs[i].tag, "_mux_idle"}, int'(bus.mux_ctrl), 0);
      chk({vecs[i].tag, "_result_hold"}, int'(bus.result), vecs[i].res);
    end

    // Start while busy and start in the done cycle must both be ignored.
    bus.op = 2'b11; bus.a = 8'd3; bus.b = 8'd4; bus.start = 1'b1;
    @(posedge clk);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("hs_result_at_done", int'(bus.result), 81);
      end
      if (bus.busy) nbusy++;
      bus.start = (i == 2) || bus.done;
      bus.op = 2'b00; bus.a = 8'd1; bus.b = 8'd1;
    end
    bus.start = 1'b0;
    chk("hs_done_count", ndone, 1);
    chk("hs_busy_cycles", nbusy, 5);
    chk("hs_result_final", int'(bus.result), 81);

    // Asynchronous reset two cycles into POW 2^5.
    bus.op = 2'b11; bus.a = 8'd2; bus.b = 8'd5; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_result", int'(bus.result), 0);
    chk("arst_mux", int'(bus.mux_ctrl), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("arst_no_done", ndone, 0);

    run_op(2'b00, 1, 1, lat, bcyc, msel);
    chk("post_rst_add", int'(bus.result), 2);
    chk("post_rst_add_latency", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
